// File: rtl/circuito_pkg.sv
`default_nettype none
// ============================================================================
// Module   : circuito_pkg
// Brief    : Shared widths and count codes for the circuito_dias population counter.
// Revision : 1.0 - initial release
// ============================================================================
package circuito_pkg;

   localparam int IN_W  = 4;
   localparam int CNT_W = 3;

   typedef logic [IN_W-1:0]  day_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_ZERO  = 3'd0;
   localparam cnt_t CNT_ONE   = 3'd1;
   localparam cnt_t CNT_TWO   = 3'd2;
   localparam cnt_t CNT_THREE = 3'd3;
   localparam cnt_t CNT_FOUR  = 3'd4;

endpackage : circuito_pkg
`default_nettype wire

// File: rtl/circuito_dias_if.sv
`default_nettype none
// ============================================================================
// Module   : circuito_dias_if
// Brief    : Condition inputs A..D and count outputs Z/Y/X of circuito_dias.
// Revision : 1.0 - initial release
// ============================================================================
interface circuito_dias_if;

   logic A;
   logic B;
   logic C;
   logic D;
   logic X;
   logic Y;
   logic Z;

   // master supplies the conditions and observes the count
   modport master (output A, B, C, D, input X, Y, Z);
   modport slave  (input A, B, C, D, output X, Y, Z);

endinterface : circuito_dias_if
`default_nettype wire

// File: rtl/popcount4.sv
`default_nettype none
// ============================================================================
// Module   : popcount4
// Brief    : Combinational count of set bits in a 4-bit word (0..4).
// Revision : 1.0 - initial release
// ============================================================================
module popcount4
   import circuito_pkg::*;
(
   input  day_t day,
   output cnt_t cnt
);

   // zero-extend each bit so the adder runs at full output width
   always_comb begin
      cnt = CNT_ZERO;
      for (int i = 0; i < IN_W; i++) begin
         cnt = cnt + cnt_t'(day[i]);
      end
   end

endmodule : popcount4
`default_nettype wire

// File: rtl/circuito_dias.sv
`default_nettype none
// ============================================================================
// Module   : circuito_dias
// Brief    : Registered 4-input population counter; count of {A,B,C,D} on {Z,Y,X}.
// Revision : 1.0 - initial release
// ============================================================================
module circuito_dias
   import circuito_pkg::*;
(
   input wire logic         clk,
   input wire logic         rst_n,
   circuito_dias_if.slave   bus
);

   day_t w_day;
   cnt_t w_cnt;
   cnt_t r_cnt;

   assign w_day = {bus.A, bus.B, bus.C, bus.D};

   popcount4 u_popcount4 (
      .day (w_day),
      .cnt (w_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= CNT_ZERO;
      end else begin
         r_cnt <= w_cnt;
      end
   end

   // outputs come only from the register, never straight from the inputs
   assign bus.Z = r_cnt[2];
   assign bus.Y = r_cnt[1];
   assign bus.X = r_cnt[0];

endmodule : circuito_dias
`default_nettype wire

// File: tb/tb_circuito_dias.sv
`default_nettype none
// ============================================================================
// Module   : tb_circuito_dias
// Brief    : Directed self-checking bench for circuito_dias.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circuito_dias;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   circuito_dias_if bus ();

   circuito_dias dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] zyx();
      return {bus.Z, bus.Y, bus.X};
   endfunction

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set_day(input logic [3:0] w);
      {bus.A, bus.B, bus.C, bus.D} = w;
   endtask

   // drive on the falling edge, check just after the following rising edge
   task automatic day_step(input string tag, input logic [3:0] w, input logic [2:0] exp);
      @(negedge clk);
      set_day(w);
      @(posedge clk);
      #1;
      chk(tag, zyx(), exp);
   endtask

   typedef struct {
      logic [3:0] w;
      logic [2:0] exp;
   } vec_t;

   vec_t dir_vecs[5];
   logic [2:0] exp_cnt;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      set_day(4'b1111);

      dir_vecs[0] = '{4'b0010, 3'b001};
      dir_vecs[1] = '{4'b1011, 3'b011};
      dir_vecs[2] = '{4'b1111, 3'b100};
      dir_vecs[3] = '{4'b1010, 3'b010};
      dir_vecs[4] = '{4'b1100, 3'b010};

      // reset held with all inputs asserted
      #1;
      chk("rst_async", zyx(), 3'b000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_hold", zyx(), 3'b000);
      end

      // first edge after release loads the inputs present at that edge
      @(negedge clk);
      rst_n = 1'b1;
      set_day(4'b0010);
      @(posedge clk);
      #1;
      chk("rst_release", zyx(), 3'b001);

      foreach (dir_vecs[i]) day_step("directed", dir_vecs[i].w, dir_vecs[i].exp);

      // mid-cycle reset after a nonzero output
      day_step("pre_rst", 4'b1111, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid", zyx(), 3'b000);
      @(posedge clk);
      #1;
      chk("rst_mid_edge", zyx(), 3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // exhaustive sweep, expected count built from the individual bits
      for (int v = 0; v < 16; v++) begin
         logic [3:0] w;
         w = 4'(v);
         exp_cnt = 3'(w[3]) + 3'(w[2]) + 3'(w[1]) + 3'(w[0]);
         day_step("exhaustive", w, exp_cnt);
         checks++;
         if (zyx() > 3'b100) begin
            failures++;
            $display("FAIL illegal_code: got %b expected <= 100", zyx());
         end
      end

      // inputs changing between edges must not reach the outputs
      day_step("glitch_pre", 4'b1111, 3'b100);
      #2;
      set_day(4'b0001);
      #1;
      chk("glitch_mid", zyx(), 3'b100);
      @(negedge clk);
      set_day(4'b0000);
      #1;
      chk("glitch_neg", zyx(), 3'b100);
      @(posedge clk);
      #1;
      chk("glitch_zero", zyx(), 3'b000);

      // alternation: each edge shows the word driven just before it
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) day_step("alt_ones", 4'b1111, 3'b100);
         else            day_step("alt_zero", 4'b0000, 3'b000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_circuito_dias
`default_nettype wire
